// File: rtl/pulse_stretcher_if.sv
// Handshake bundle between an event source and the pulse stretcher.
// The source drives pulse_in/cancel; the stretcher returns the level and strobes.
interface pulse_stretcher_if;
    logic pulse_in;
    logic cancel;
    logic level_out;
    logic busy;
    logic fall_pulse;
    logic missed_pulse;

    modport master (
        output pulse_in, cancel,
        input  level_out, busy, fall_pulse, missed_pulse
    );

    modport slave (
        input  pulse_in, cancel,
        output level_out, busy, fall_pulse, missed_pulse
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle pulses into a level of WIDTH_CYCLES cycles, with
// optional retrigger, a post-pulse holdoff window and dropped-pulse reporting.
// All outputs are registered from the next-state decode, so a pulse sampled
// at edge k shows up on level_out right after that same edge.
module pulse_stretcher #(
    parameter int WIDTH_CYCLES   = 4,
    parameter int HOLDOFF_CYCLES = 0,
    parameter int RETRIGGER      = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    pulse_stretcher_if.slave  bus
);

    // Counter holds "edges remaining minus one", so it never needs more than
    // max(W,H)-1.
    localparam int MAX_C = (WIDTH_CYCLES > HOLDOFF_CYCLES) ? WIDTH_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(WIDTH_CYCLES - 1);
    localparam logic [CNT_W-1:0] H_LOAD = (HOLDOFF_CYCLES > 0) ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_busy;
    logic             r_fall;
    logic             r_miss;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_fall_nxt;
    logic             w_miss_nxt;

    // Next-state and strobe decode. The final HOLDOFF edge (counter at zero)
    // already behaves like IDLE, so a pulse there is accepted without a gap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fall_nxt  = 1'b0;
        w_miss_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.pulse_in) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = W_LOAD;
                end
            end

            ACTIVE: begin
                if (bus.cancel || (r_cnt == '0 && !(HOLDOFF_CYCLES == 0 && bus.pulse_in))) begin
                    // Leaving the high time: cancel, or expiry with no
                    // seamless re-accept. A pulse here is dropped.
                    w_fall_nxt = 1'b1;
                    w_miss_nxt = bus.pulse_in;
                    if (HOLDOFF_CYCLES > 0) begin
                        w_state_nxt = HOLDOFF;
                        w_cnt_nxt   = H_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else if (r_cnt == '0) begin
                    // Expiry edge with no holdoff: the pulse starts a fresh
                    // high time and the level never drops.
                    w_cnt_nxt = W_LOAD;
                end else if (bus.pulse_in) begin
                    if (RETRIGGER != 0) begin
                        w_cnt_nxt = W_LOAD;
                    end else begin
                        w_miss_nxt = 1'b1;
                        w_cnt_nxt  = r_cnt - ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end

            HOLDOFF: begin
                if (r_cnt == '0) begin
                    if (bus.pulse_in) begin
                        w_state_nxt = ACTIVE;
                        w_cnt_nxt   = W_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_miss_nxt = bus.pulse_in;
                    w_cnt_nxt  = r_cnt - ONE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset drops everything at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_busy  <= 1'b0;
            r_fall  <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= (w_state_nxt == ACTIVE);
            r_busy  <= (w_state_nxt != IDLE);
            r_fall  <= w_fall_nxt;
            r_miss  <= w_miss_nxt;
        end
    end

    assign bus.level_out    = r_level;
    assign bus.busy         = r_busy;
    assign bus.fall_pulse   = r_fall;
    assign bus.missed_pulse = r_miss;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: five configurations side by side, a timestamp
// model checked every cycle, and hand-written per-edge output masks.
module tb_pulse_stretcher;

    localparam int ND = 5;
    // Configurations: 0 W4/H0/R1, 1 W4/H2/R0, 2 W4/H0/R0, 3 W8/H3/R1, 4 W1/H0/R1
    int PW [ND] = '{4, 4, 4, 8, 1};
    int PH [ND] = '{0, 2, 0, 3, 0};
    int PR [ND] = '{1, 0, 0, 1, 1};

    logic clock = 1'b0;
    logic reset_n;
    logic [ND-1:0] p;
    logic [ND-1:0] c;
    wire  [ND-1:0] o_lvl, o_busy, o_fall, o_miss;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clock = ~clock;

    pulse_stretcher_if u_if [ND] ();

    for (genvar g = 0; g < ND; g++) begin : g_bind
        assign u_if[g].pulse_in  = p[g];
        assign u_if[g].cancel    = c[g];
        assign o_lvl[g]  = u_if[g].level_out;
        assign o_busy[g] = u_if[g].busy;
        assign o_fall[g] = u_if[g].fall_pulse;
        assign o_miss[g] = u_if[g].missed_pulse;
    end

    pulse_stretcher #(.WIDTH_CYCLES(4), .HOLDOFF_CYCLES(0), .RETRIGGER(1))
        u_dut0 (.clock(clock), .reset_n(reset_n), .bus(u_if[0]));
    pulse_stretcher #(.WIDTH_CYCLES(4), .HOLDOFF_CYCLES(2), .RETRIGGER(0))
        u_dut1 (.clock(clock), .reset_n(reset_n), .bus(u_if[1]));
    pulse_stretcher #(.WIDTH_CYCLES(4), .HOLDOFF_CYCLES(0), .RETRIGGER(0))
        u_dut2 (.clock(clock), .reset_n(reset_n), .bus(u_if[2]));
    pulse_stretcher #(.WIDTH_CYCLES(8), .HOLDOFF_CYCLES(3), .RETRIGGER(1))
        u_dut3 (.clock(clock), .reset_n(reset_n), .bus(u_if[3]));
    pulse_stretcher #(.WIDTH_CYCLES(1), .HOLDOFF_CYCLES(0), .RETRIGGER(1))
        u_dut4 (.clock(clock), .reset_n(reset_n), .bus(u_if[4]));

    // Edge counter used as the model's time base.
    always @(posedge clock) cyc <= cyc + 1;

    // Timestamp model: act_end = edge at which the high time expires,
    // free_at = first edge at which a new pulse may be accepted.
    int act_end [ND] = '{default: -100};
    int free_at [ND] = '{default: -100};
    logic [ND-1:0] m_lvl = '0, m_busy = '0, m_fall = '0, m_miss = '0;
    int   mn, mae, mfa;
    logic mact, mf, mm;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int d = 0; d < ND; d++) begin
                act_end[d] <= -100;
                free_at[d] <= -100;
            end
            m_lvl  <= '0;
            m_busy <= '0;
            m_fall <= '0;
            m_miss <= '0;
        end else begin
            for (int d = 0; d < ND; d++) begin
                mn   = cyc;
                mae  = act_end[d];
                mfa  = free_at[d];
                mf   = 1'b0;
                mm   = 1'b0;
                mact = (mn < mae);
                if (mact && c[d]) begin
                    mae = mn;
                    mfa = mn + PH[d];
                    mf  = 1'b1;
                    mm  = p[d];
                end else if (mact && p[d]) begin
                    if (PR[d] != 0) begin
                        mae = mn + PW[d];
                        mfa = mae + PH[d];
                    end else begin
                        mm = 1'b1;
                    end
                end else if (!mact) begin
                    if (p[d] && mn >= mfa) begin
                        mae = mn + PW[d];
                        mfa = mae + PH[d];
                    end else begin
                        mm = p[d];
                        mf = (mn == mae);
                    end
                end
                act_end[d] <= mae;
                free_at[d] <= mfa;
                m_lvl[d]   <= (mn < mae);
                m_busy[d]  <= (mn < mae) || (mn < mfa);
                m_fall[d]  <= mf;
                m_miss[d]  <= mm;
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clock) begin
        for (int d = 0; d < ND; d++) begin
            n_tests++;
            if ({o_lvl[d], o_busy[d], o_fall[d], o_miss[d]} !==
                {m_lvl[d], m_busy[d], m_fall[d], m_miss[d]}) begin
                n_fail++;
                $display("FAIL model_cmp dut%0d cyc %0d: lvl/busy/fall/miss got %b%b%b%b want %b%b%b%b",
                         d, cyc, o_lvl[d], o_busy[d], o_fall[d], o_miss[d],
                         m_lvl[d], m_busy[d], m_fall[d], m_miss[d]);
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drives one scenario on instance d; bit e of pm/cm/rm applies to relative
    // edge e (rm = reset held low at that edge). Records each output after
    // every edge into a mask and compares against the expected masks.
    task automatic run_scen(input string nm, input int d, input int len,
                            input logic [63:0] pm, input logic [63:0] cm, input logic [63:0] rm,
                            input logic [63:0] el, input logic [63:0] eb,
                            input logic [63:0] ef, input logic [63:0] em);
        logic [63:0] tl, tb, tf, tm;
        tl = '0; tb = '0; tf = '0; tm = '0;
        for (int e = 1; e <= len; e++) begin
            p[d] = pm[e];
            c[d] = cm[e];
            if (rm[e] && reset_n) begin
                reset_n = 1'b0;
                #1;
                check({nm, "_async_rst"}, {60'd0, o_lvl[d], o_busy[d], o_fall[d], o_miss[d]}, 64'd0);
            end else if (!rm[e]) begin
                reset_n = 1'b1;
            end
            @(negedge clock);
            tl[e] = o_lvl[d];
            tb[e] = o_busy[d];
            tf[e] = o_fall[d];
            tm[e] = o_miss[d];
            #1;
        end
        p[d] = 1'b0;
        c[d] = 1'b0;
        check({nm, "_level"}, tl, el);
        check({nm, "_busy"},  tb, eb);
        check({nm, "_fall"},  tf, ef);
        check({nm, "_miss"},  tm, em);
    endtask

    initial begin
        reset_n = 1'b0;
        p = '0;
        c = '0;
        repeat (3) @(negedge clock);
        check("reset_state", {44'd0, o_lvl, o_busy, o_fall, o_miss}, 64'd0);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        #1;

        // single pulse at 10: high after 10..13, fall after 14
        run_scen("t1_single", 0, 20, 64'h400, 64'h0, 64'h0,
                 64'h3C00, 64'h3C00, 64'h4000, 64'h0);
        // retrigger at 12: high 10..15, one fall after 16
        run_scen("t2_retrig", 0, 20, 64'h1400, 64'h0, 64'h0,
                 64'hFC00, 64'hFC00, 64'h10000, 64'h0);
        // no retrigger, holdoff 2: misses at 12,14,15; accept at 16
        run_scen("t3_holdoff", 1, 24, 64'h1D400, 64'h0, 64'h0,
                 64'hF3C00, 64'h3FFC00, 64'h104000, 64'hD000);
        // pulse on expiry edge with no holdoff: continuous high to 17
        run_scen("t4_expiry", 2, 22, 64'h4400, 64'h0, 64'h0,
                 64'h3FC00, 64'h3FC00, 64'h40000, 64'h0);
        // cancel with pulse at 7: fall and miss together, busy ends after 9
        run_scen("t5_cancel", 3, 14, 64'hA0, 64'h80, 64'h0,
                 64'h60, 64'h3E0, 64'h80, 64'h80);
        // async reset between edges 6 and 7, released for edge 9, new pulse at 12
        run_scen("t6_reset", 3, 26, 64'h1020, 64'h0, 64'h180,
                 64'hFF060, 64'h7FF060, 64'h100000, 64'h0);
        // width 1: pulses 3,6,7 (7 lands on expiry edge of 6)
        run_scen("t7_w1", 4, 12, 64'hC8, 64'h0, 64'h0,
                 64'hC8, 64'hC8, 64'h110, 64'h0);
        // cancel in idle (1) and holdoff (7) ignored; pulse on holdoff end (8) accepted
        run_scen("t8_cancel_idle", 1, 16, 64'h104, 64'h82, 64'h0,
                 64'hF3C, 64'h3FFC, 64'h1040, 64'h0);
        // cancel+pulse at 4 with no holdoff, then immediate re-accept at 5
        run_scen("t9_cancel_h0", 0, 12, 64'h34, 64'h10, 64'h0,
                 64'h1EC, 64'h1EC, 64'h210, 64'h10);

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle pulses back into levels: the inverse of the team's level-to-pulse edge detector.
- Each accepted `pulse_in` drives `level_out` high for a programmable number of clock cycles.
- Supports an optional retrigger and a post-pulse holdoff window; reports dropped pulses.
- Sits between event sources (edge detectors, timers, button logic) and slow consumers such as LED/7-segment blanking and strobes that need a minimum visible width.

Parameters:
- WIDTH_CYCLES, 4: high time of `level_out` per accepted pulse, in clock cycles; legal range ≥1.
- HOLDOFF_CYCLES, 0: cycles after `level_out` falls during which pulses are rejected; legal range ≥0.
- RETRIGGER, 1: 1 = a pulse while high restarts the width count; 0 = a pulse while high is rejected.
- CNT_W, derived from the larger of WIDTH_CYCLES and HOLDOFF_CYCLES: counter width; internal only, not overridable.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pulse_in  input  1  trigger, synchronous to `clock`; a high sample at any edge is one event, so a multi-cycle high is one event per edge.
- cancel  input  1  synchronous abort of the current high time.
- level_out  output  1  stretched level, registered.
- busy  output  1  high while `level_out` is high or holdoff is running, registered.
- fall_pulse  output  1  one-cycle strobe marking the falling edge of `level_out`, registered.
- missed_pulse  output  1  one-cycle strobe: the `pulse_in` sampled at the same edge was rejected, registered.

Behaviour:
- Reset (`reset_n` low, asynchronous):
  - all outputs 0, state IDLE, counter 0.
  - Reset asserted mid-ACTIVE drops `level_out` immediately with no `fall_pulse`.
  - Release is synchronous to the next edge.
- States: IDLE, ACTIVE, HOLDOFF.
- IDLE:
  - `pulse_in`=1 at edge k: go to ACTIVE.
  - `level_out` and `busy` read 1 after edge k (zero-cycle input-to-register latency).
- ACTIVE, no further events:
  - `level_out` stays high exactly WIDTH_CYCLES cycles; it reads 0 after edge k+WIDTH_CYCLES.
  - `fall_pulse` reads 1 for that one cycle only.
  - Next state is HOLDOFF if HOLDOFF_CYCLES>0, else IDLE.
- ACTIVE, `pulse_in`=1 at edge j (k<j<k+WIDTH_CYCLES):
  - RETRIGGER=1: count restarts; the fall moves to edge j+WIDTH_CYCLES; no `missed_pulse`.
  - RETRIGGER=0: pulse ignored; `missed_pulse`=1 for the cycle after edge j.
- Pulse sampled at the expiry edge k+WIDTH_CYCLES:
  - HOLDOFF_CYCLES=0, either RETRIGGER: accepted as a new event; `level_out` stays high continuously, no `fall_pulse`, new high time ends at edge k+2·WIDTH_CYCLES.
  - HOLDOFF_CYCLES>0: this edge is the first holdoff edge, so the pulse is rejected with `missed_pulse`.
- HOLDOFF:
  - Spans edges k+W .. k+W+H−1 (W = WIDTH_CYCLES, H = HOLDOFF_CYCLES).
  - Pulses sampled in that window are rejected with `missed_pulse`.
  - `busy` stays 1 throughout and goes 0 after edge k+W+H.
  - A pulse at edge k+W+H is accepted: `level_out` goes 1 and `busy` stays 1.
- `cancel`=1 at an edge in ACTIVE:
  - `level_out` reads 0 after that edge, with `fall_pulse`=1.
  - Then enters HOLDOFF (full H cycles) or IDLE.
- `cancel` in IDLE or HOLDOFF: no effect (holdoff is not shortened).
- `cancel` and `pulse_in` at the same edge: cancel wins; a `pulse_in` that would otherwise have been accepted is reported as `missed_pulse`.
- WIDTH_CYCLES=1: every accepted pulse yields a one-cycle `level_out`; `fall_pulse` follows on the next cycle.
- `missed_pulse` and `fall_pulse` can both be 1 in the same cycle.
- Counter arithmetic is unsigned down-count; no wrap is reachable in legal configurations.

Test Plan:
1. W=4, H=0, R=1: single `pulse_in` at edge 10 → `level_out` high after edges 10–13, low after 14; `fall_pulse` high only after edge 14; `busy` mirrors `level_out`.
2. W=4, H=0, R=1: pulses at edges 10 and 12 → `level_out` continuously high through edge 15, low after 16, exactly one `fall_pulse`, no `missed_pulse`.
3. W=4, H=2, R=0: pulses at edges 10, 12, 14, 15, 16 →
   - edge 12: `missed_pulse` (ACTIVE, no retrigger)
   - edges 14, 15: `missed_pulse` (holdoff)
   - edge 16: accepted; `level_out` high after 16, low after 20
   - `busy` low only in the cycle after edge 16? No: `busy` stays high from edge 10 through holdoff into the new high time.
4. W=4, H=0, R=0: pulse at edge 10 and at expiry edge 14 → `level_out` high continuously, falls after edge 18, no `fall_pulse` at 14, no `missed_pulse`.
5. W=8, H=3: pulse at edge 5, `cancel` at edge 7 together with `pulse_in` → `level_out` low after edge 7, `fall_pulse` and `missed_pulse` both 1 after edge 7, `busy` low after edge 10.
6. W=8: pulse at edge 5, `reset_n` low mid-cycle between edges 6 and 7 → all outputs 0 immediately, no `fall_pulse`; after release, pulse at edge 12 behaves as in scenario 1.
